usb_rx_nrzi_unstuff: RTL and testbench

- Sits directly downstream of the data recovery block, in the 480 MHz domain.
- Takes the recovered serial HS line bit each cycle, performs NRZI decoding, detects the SYNC field and removes stuffed bits.
- Deserializes LSB-first into bytes and detects EOP, stuff-error aborts and babble.
- Feeds the packet decoder with a byte/valid/active/error interface.

---
 rtl/usb_rx_nrzi_unstuff.sv | 145 ++++++++++++++
 tb/tb_usb_rx_nrzi_unstuff.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_nrzi_unstuff.sv
// HS receive front end: NRZI decode, SYNC hunt, bit unstuffing and LSB-first
// deserialisation with EOP, stuff-error, squelch-abort and babble detection.
module usb_rx_nrzi_unstuff #(
    parameter int SYNC_MIN_ZEROS = 12,
    parameter int MAX_BYTES      = 1027
) (
    input  logic       clock_480,
    input  logic       reset,
    input  logic       data_in,
    input  logic       squelch,
    output logic       rx_active,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_error
);

    localparam int ZW = $clog2(SYNC_MIN_ZEROS + 1);
    localparam int BW = $clog2(MAX_BYTES + 2);
    localparam logic [ZW-1:0] SYNC_MIN_C = ZW'(SYNC_MIN_ZEROS);
    localparam logic [BW-1:0] BABBLE_C   = BW'(MAX_BYTES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HUNT  = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t          state_r;
    logic            prev_line_r;
    logic [ZW-1:0]   zero_cnt_r;
    logic [2:0]      bit_cnt_r;
    logic [2:0]      ones_cnt_r;
    logic [BW-1:0]   byte_cnt_r;
    logic [7:0]      shreg_r;
    logic            rx_active_r;
    logic            rx_valid_r;
    logic [7:0]      rx_data_r;
    logic            rx_error_r;

    logic            decoded_s;
    logic [7:0]      shifted_s;
    logic [BW-1:0]   byte_cnt_inc_s;

    // NRZI decode (no transition = 1) and the next shift-register value
    always_comb begin
        decoded_s      = (data_in == prev_line_r);
        shifted_s      = {decoded_s, shreg_r[7:1]};
        byte_cnt_inc_s = byte_cnt_r + BW'(1);
    end

    // Receive state machine with registered outputs
    always_ff @(posedge clock_480 or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            prev_line_r <= 1'b0;
            zero_cnt_r  <= '0;
            bit_cnt_r   <= 3'd0;
            ones_cnt_r  <= 3'd0;
            byte_cnt_r  <= '0;
            shreg_r     <= 8'h00;
            rx_active_r <= 1'b0;
            rx_valid_r  <= 1'b0;
            rx_data_r   <= 8'h00;
            rx_error_r  <= 1'b0;
        end else begin
            prev_line_r <= data_in;
            rx_valid_r  <= 1'b0;
            rx_error_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    zero_cnt_r <= '0;
                    if (!squelch) begin
                        state_r <= ST_HUNT;
                    end
                end
                ST_HUNT: begin
                    if (squelch) begin
                        state_r    <= ST_IDLE;
                        zero_cnt_r <= '0;
                    end else if (!decoded_s) begin
                        if (zero_cnt_r < SYNC_MIN_C) begin
                            zero_cnt_r <= zero_cnt_r + ZW'(1);
                        end
                    end else if (zero_cnt_r >= SYNC_MIN_C) begin
                        state_r     <= ST_DATA;
                        rx_active_r <= 1'b1;
                        zero_cnt_r  <= '0;
                        bit_cnt_r   <= 3'd0;
                        ones_cnt_r  <= 3'd0;
                        byte_cnt_r  <= '0;
                        shreg_r     <= 8'h00;
                    end else begin
                        zero_cnt_r <= '0;
                    end
                end
                ST_DATA: begin
                    if (squelch) begin
                        // Losing the line mid-byte is an abort; at a byte boundary it is benign
                        state_r     <= ST_IDLE;
                        rx_active_r <= 1'b0;
                        rx_error_r  <= (bit_cnt_r != 3'd0);
                    end else if (ones_cnt_r == 3'd6) begin
                        ones_cnt_r <= 3'd0;
                        if (decoded_s) begin
                            // Seventh one: EOP only when it completes the 0+six-1s pattern
                            state_r     <= ST_DRAIN;
                            rx_active_r <= 1'b0;
                            rx_error_r  <= (bit_cnt_r != 3'd7);
                        end
                    end else begin
                        shreg_r    <= shifted_s;
                        ones_cnt_r <= decoded_s ? (ones_cnt_r + 3'd1) : 3'd0;
                        bit_cnt_r  <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            rx_data_r  <= shifted_s;
                            rx_valid_r <= 1'b1;
                            byte_cnt_r <= byte_cnt_inc_s;
                            if (byte_cnt_inc_s == BABBLE_C) begin
                                state_r     <= ST_DRAIN;
                                rx_active_r <= 1'b0;
                                rx_error_r  <= 1'b1;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (squelch) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    rx_active_r <= 1'b0;
                end
            endcase
        end
    end

    assign rx_active = rx_active_r;
    assign rx_valid  = rx_valid_r;
    assign rx_data   = rx_data_r;
    assign rx_error  = rx_error_r;

endmodule

// File: tb/tb_usb_rx_nrzi_unstuff.sv
// Directed and randomized packets encoded by a bit-level USB HS line model;
// received bytes, strobe timing, errors and rx_active edges are compared.
module tb_usb_rx_nrzi_unstuff;

    logic       clock_480 = 1'b0;
    logic       reset;
    logic       data_in;
    logic       squelch;
    logic       rx_active;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_error;

    usb_rx_nrzi_unstuff dut (
        .clock_480 (clock_480),
        .reset     (reset),
        .data_in   (data_in),
        .squelch   (squelch),
        .rx_active (rx_active),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_error  (rx_error)
    );

    always #5 clock_480 = ~clock_480;

    int cyc = 0;
    always @(posedge clock_480) cyc <= cyc + 1;

    // Output monitor: everything the DUT reports, stamped with the cycle count
    logic [7:0] byte_q[$];
    int         vcyc_q[$];
    int         err_q[$];
    int         rise_q[$];
    int         fall_q[$];
    int         both_cnt = 0;
    int         viol_cnt = 0;
    logic       act_prev = 1'b0;

    always @(negedge clock_480) begin
        if (rx_valid) begin
            byte_q.push_back(rx_data);
            vcyc_q.push_back(cyc);
            if (rx_error) both_cnt <= both_cnt + 1;
            else if (!rx_active) viol_cnt <= viol_cnt + 1;
        end
        if (rx_error) err_q.push_back(cyc);
        if (rx_active && !act_prev) rise_q.push_back(cyc);
        if (!rx_active && act_prev) fall_q.push_back(cyc);
        act_prev <= rx_active;
    end

    // Line model: decoded symbols, expected bytes and index of each byte's last bit
    logic       sym_q[$];
    logic [7:0] exp_b[$];
    int         exp_i[$];
    int         ones_run;
    int         sync_idx;
    logic       line = 1'b1;
    int         start_cyc;
    int         b_base, e_base, r_base, f_base, both_base, viol_base;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_pkt();
        sym_q.delete();
        exp_b.delete();
        exp_i.delete();
        ones_run = 0;
        sync_idx = -1;
    endtask

    task automatic add_raw(input logic b);
        sym_q.push_back(b);
    endtask

    task automatic add_sync(input int zeros);
        for (int i = 0; i < zeros; i++) sym_q.push_back(1'b0);
        sym_q.push_back(1'b1);
        sync_idx = sym_q.size() - 1;
        ones_run = 0;
    endtask

    task automatic add_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            sym_q.push_back(b[i]);
            ones_run = b[i] ? ones_run + 1 : 0;
            if (i == 7) begin
                exp_b.push_back(b);
                exp_i.push_back(sym_q.size() - 1);
            end
            if (ones_run == 6) begin
                sym_q.push_back(1'b0);
                ones_run = 0;
            end
        end
    endtask

    task automatic add_eop();
        sym_q.push_back(1'b0);
        for (int i = 0; i < 7; i++) sym_q.push_back(1'b1);
    endtask

    task automatic tick(input logic sq, input logic d);
        squelch = sq;
        data_in = d;
        @(posedge clock_480);
        #1;
    endtask

    task automatic snap();
        b_base    = byte_q.size();
        e_base    = err_q.size();
        r_base    = rise_q.size();
        f_base    = fall_q.size();
        both_base = both_cnt;
        viol_base = viol_cnt;
    endtask

    // One squelch-low cycle, the NRZI-encoded symbols, an unsquelched tail, then squelch
    task automatic send(input int tail, input int sq_cycles);
        snap();
        tick(1'b0, line);
        start_cyc = cyc;
        for (int i = 0; i < sym_q.size(); i++) begin
            if (!sym_q[i]) line = ~line;
            tick(1'b0, line);
        end
        for (int i = 0; i < tail; i++) tick(1'b0, line);
        for (int i = 0; i < sq_cycles; i++) tick(1'b1, line);
    endtask

    task automatic verify(input string tag, input int exp_errs, input int evt_cyc,
                          input int exp_rises, input int exp_both);
        int nb;
        nb = byte_q.size() - b_base;
        check({tag, ".nbytes"}, 32'(nb), 32'(exp_b.size()));
        for (int k = 0; k < exp_b.size() && k < nb; k++) begin
            check({tag, ".data"}, 32'(byte_q[b_base + k]), 32'(exp_b[k]));
            check({tag, ".vcyc"}, 32'(vcyc_q[b_base + k]), 32'(start_cyc + exp_i[k] + 1));
        end
        check({tag, ".nerr"}, 32'(err_q.size() - e_base), 32'(exp_errs));
        if (exp_errs > 0 && err_q.size() > e_base)
            check({tag, ".errcyc"}, 32'(err_q[e_base]), 32'(evt_cyc));
        check({tag, ".nrise"}, 32'(rise_q.size() - r_base), 32'(exp_rises));
        if (exp_rises > 0 && rise_q.size() > r_base)
            check({tag, ".risecyc"}, 32'(rise_q[r_base]), 32'(start_cyc + sync_idx + 1));
        if (exp_rises > 0 && fall_q.size() > f_base)
            check({tag, ".fallcyc"}, 32'(fall_q[f_base]), 32'(evt_cyc));
        check({tag, ".both"}, 32'(both_cnt - both_base), 32'(exp_both));
        check({tag, ".inactive_valid"}, 32'(viol_cnt - viol_base), 32'd0);
        check({tag, ".active_end"}, 32'(rx_active), 32'd0);
    endtask

    initial begin
        int err_idx;
        int len;
        reset   = 1'b1;
        squelch = 1'b1;
        data_in = 1'b1;
        repeat (3) @(posedge clock_480);
        #1;
        check("reset.active", 32'(rx_active), 32'd0);
        check("reset.valid", 32'(rx_valid), 32'd0);
        check("reset.data", 32'(rx_data), 32'h00);
        check("reset.error", 32'(rx_error), 32'd0);
        reset = 1'b0;
        repeat (3) tick(1'b1, line);

        // Nominal packet
        clear_pkt();
        add_sync(31);
        add_byte(8'hC3); add_byte(8'h00); add_byte(8'hFF); add_byte(8'h5A);
        add_eop();
        send(5, 4);
        verify("nominal", 0, start_cyc + sym_q.size(), 1, 0);

        // Randomized packets
        for (int p = 0; p < 5; p++) begin
            clear_pkt();
            add_sync($urandom_range(31, 12));
            len = $urandom_range(24, 1);
            for (int k = 0; k < len; k++) add_byte(8'($urandom));
            add_eop();
            send($urandom_range(6, 0), 3);
            verify("random", 0, start_cyc + sym_q.size(), 1, 0);
        end

        // Minimal SYNC accepted
        clear_pkt();
        add_sync(12);
        add_byte(8'hA5);
        add_eop();
        send(3, 3);
        verify("sync12", 0, start_cyc + sym_q.size(), 1, 0);

        // One zero short: never synchronises
        clear_pkt();
        add_sync(11);
        add_byte(8'hA5);
        add_eop();
        exp_b.delete();
        exp_i.delete();
        send(3, 3);
        verify("sync11", 0, -1, 0, 0);

        // Stuffing stretches two FF bytes by two bit times
        clear_pkt();
        add_sync(31);
        add_byte(8'hFF); add_byte(8'hFF);
        add_eop();
        send(2, 3);
        verify("stuff", 0, start_cyc + sym_q.size(), 1, 0);
        if (vcyc_q.size() >= b_base + 2) begin
            check("stuff.gap", 32'(vcyc_q[b_base + 1] - vcyc_q[b_base]), 32'd9);
            check("stuff.span", 32'(vcyc_q[b_base + 1]), 32'(start_cyc + sync_idx + 19));
        end

        // Seven ones starting at bit 2 of a byte
        clear_pkt();
        add_sync(31);
        add_byte(8'h00);
        add_raw(1'b0); add_raw(1'b0);
        for (int k = 0; k < 7; k++) begin
            add_raw(1'b1);
            if (k == 5) begin
                exp_b.push_back(8'hFC);
                exp_i.push_back(sym_q.size() - 1);
            end
        end
        err_idx = sym_q.size() - 1;
        for (int k = 0; k < 24; k++) add_raw(1'($urandom));
        send(0, 3);
        verify("stufferr", 1, start_cyc + err_idx + 1, 1, 0);

        // Squelch three bits into a byte
        clear_pkt();
        add_sync(20);
        add_byte(8'h11);
        add_raw(1'b1); add_raw(1'b0); add_raw(1'b1);
        send(0, 3);
        verify("sqabort", 1, start_cyc + sym_q.size() + 1, 1, 0);

        // Squelch exactly at a byte boundary
        clear_pkt();
        add_sync(20);
        add_byte(8'h22); add_byte(8'h33);
        send(0, 3);
        verify("sqbound", 0, start_cyc + sym_q.size() + 1, 1, 0);

        // Babble: 1028 zero bytes
        clear_pkt();
        add_sync(31);
        for (int k = 0; k < 1028; k++) add_byte(8'h00);
        add_eop();
        send(2, 3);
        verify("babble", 1, start_cyc + exp_i[1027] + 1, 1, 1);

        // Asynchronous reset mid-packet
        clear_pkt();
        add_sync(31);
        add_byte(8'hA5);
        add_raw(1'b1); add_raw(1'b0); add_raw(1'b1);
        tick(1'b0, line);
        for (int i = 0; i < sym_q.size(); i++) begin
            if (!sym_q[i]) line = ~line;
            tick(1'b0, line);
        end
        check("midrst.pre_active", 32'(rx_active), 32'd1);
        check("midrst.pre_data", 32'(rx_data), 32'hA5);
        #2;
        reset = 1'b1;
        #1;
        check("midrst.active", 32'(rx_active), 32'd0);
        check("midrst.valid", 32'(rx_valid), 32'd0);
        check("midrst.data", 32'(rx_data), 32'h00);
        check("midrst.error", 32'(rx_error), 32'd0);
        squelch = 1'b1;
        @(posedge clock_480);
        #1;
        reset = 1'b0;
        repeat (3) tick(1'b1, line);

        // Clean packet after reset
        clear_pkt();
        add_sync(16);
        add_byte(8'h3C); add_byte(8'h81);
        add_eop();
        send(2, 3);
        verify("postrst", 0, start_cyc + sym_q.size(), 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
